// File: rtl/mult_eval_sweep.sv
// Exhaustive evaluation harness for one combinational or pipelined multiplier candidate.
// Sweeps all operand pairs, checks each product against a golden a*b, and reports errors.
module mult_eval_sweep #(
    parameter int WIDTH    = 2,
    parameter int PIPE_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     dut_a,
    output logic [WIDTH-1:0]     dut_b,
    input  logic [2*WIDTH-1:0]   dut_p,
    output logic [2*WIDTH:0]     err_count,
    output logic                 first_err_valid,
    output logic [WIDTH-1:0]     first_err_a,
    output logic [WIDTH-1:0]     first_err_b,
    output logic [2*WIDTH-1:0]   first_err_p,
    output logic                 pass
);

    // state   | meaning
    // S_IDLE  | waiting for start, operands held at 0
    // S_SWEEP | presenting vector r_idx to the multiplier
    // S_DRAIN | waiting PIPE_LAT cycles for the last products
    // S_DONE  | one-cycle done pulse, results final
    localparam int PW  = 2 * WIDTH;
    localparam int DCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PW-1:0]    r_idx;
    logic [PW-1:0]    w_idx_nxt;
    logic [DCW-1:0]   r_drain_cnt;
    logic             w_last_vec;
    logic             w_drain_end;
    logic             w_accept;

    logic             w_in_valid;
    logic [PW-1:0]    w_in_p;
    logic             w_chk_valid;
    logic [WIDTH-1:0] w_chk_a;
    logic [WIDTH-1:0] w_chk_b;
    logic [PW-1:0]    w_chk_p;
    logic             w_mismatch;
    logic [PW:0]      w_err_nxt;

    assign w_last_vec  = &r_idx;
    assign w_drain_end = (r_drain_cnt == '0);
    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_idx_nxt   = (r_state == S_SWEEP) ? r_idx + 1'b1 : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_SWEEP;
            S_SWEEP: if (w_last_vec) w_state_nxt = (PIPE_LAT > 0) ? S_DRAIN : S_DONE;
            S_DRAIN: if (w_drain_end) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            dut_a       <= '0;
            dut_b       <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_state_nxt == S_SWEEP) begin
                dut_a <= w_idx_nxt[WIDTH-1:0];
                dut_b <= w_idx_nxt[PW-1:WIDTH];
            end else begin
                dut_a <= '0;
                dut_b <= '0;
            end
            // Down-counter loaded on every sweep cycle so it is ready on DRAIN entry.
            if (r_state == S_SWEEP)
                r_drain_cnt <= DCW'(PIPE_LAT - 1);
            else if (r_state == S_DRAIN && !w_drain_end)
                r_drain_cnt <= r_drain_cnt - 1'b1;
        end
    end

    assign busy = (r_state == S_SWEEP) || (r_state == S_DRAIN);
    assign done = (r_state == S_DONE);

    assign w_in_valid = (r_state == S_SWEEP);
    assign w_in_p     = PW'(dut_a) * PW'(dut_b);

    generate
        if (PIPE_LAT == 0) begin : g_nodelay
            assign w_chk_valid = w_in_valid;
            assign w_chk_a     = dut_a;
            assign w_chk_b     = dut_b;
            assign w_chk_p     = w_in_p;
        end else begin : g_delay
            logic [PIPE_LAT-1:0] r_pv;
            logic [WIDTH-1:0]    r_pa [PIPE_LAT];
            logic [WIDTH-1:0]    r_pb [PIPE_LAT];
            logic [PW-1:0]       r_pp [PIPE_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pv <= '0;
                end else begin
                    r_pv[0] <= w_in_valid;
                    for (int i = 1; i < PIPE_LAT; i++)
                        r_pv[i] <= r_pv[i-1];
                end
            end

            always_ff @(posedge clk) begin
                r_pa[0] <= dut_a;
                r_pb[0] <= dut_b;
                r_pp[0] <= w_in_p;
                for (int i = 1; i < PIPE_LAT; i++) begin
                    r_pa[i] <= r_pa[i-1];
                    r_pb[i] <= r_pb[i-1];
                    r_pp[i] <= r_pp[i-1];
                end
            end

            assign w_chk_valid = r_pv[PIPE_LAT-1];
            assign w_chk_a     = r_pa[PIPE_LAT-1];
            assign w_chk_b     = r_pb[PIPE_LAT-1];
            assign w_chk_p     = r_pp[PIPE_LAT-1];
        end
    endgenerate

    assign w_mismatch = w_chk_valid && (dut_p != w_chk_p);
    assign w_err_nxt  = err_count + {{PW{1'b0}}, w_mismatch};

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_p     <= '0;
            pass            <= 1'b0;
        end else begin
            err_count <= w_err_nxt;
            if (w_mismatch && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_a     <= w_chk_a;
                first_err_b     <= w_chk_b;
                first_err_p     <= dut_p;
            end
            // The last compare closes on the same edge that enters DONE.
            if (w_state_nxt == S_DONE && r_state != S_DONE)
                pass <= (w_err_nxt == '0);
        end
    end

endmodule

// File: tb/tb_mult_eval_sweep.sv
// Directed bench for mult_eval_sweep: golden, faulty and pipelined multiplier models.
module tb_mult_eval_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mode   = 0;

    logic       rst0 = 1'b0, start0 = 1'b0;
    logic       busy0, done0, fev0, pass0;
    logic [1:0] a0, b0, fea0, feb0;
    logic [3:0] p0, fep0;
    logic [4:0] err0;

    logic       rst2 = 1'b0, start2 = 1'b0;
    logic       busy2, done2, fev2, pass2;
    logic [1:0] a2, b2, fea2, feb2;
    logic [3:0] p2, fep2;
    logic [4:0] err2;

    logic [3:0] s1_0, s2_0, s1_2, s2_2;

    always @(posedge clk) begin
        s1_0 <= {2'b00, a0} * {2'b00, b0};
        s2_0 <= s1_0;
        s1_2 <= {2'b00, a2} * {2'b00, b2};
        s2_2 <= s1_2;
    end

    always_comb begin
        case (mode)
            1:       p0 = 4'd0;
            2:       p0 = ({2'b00, a0} * {2'b00, b0}) & 4'b1110;
            3:       p0 = s2_0;
            default: p0 = {2'b00, a0} * {2'b00, b0};
        endcase
    end
    assign p2 = s2_2;

    mult_eval_sweep #(.WIDTH(2), .PIPE_LAT(0)) u0 (
        .clk(clk), .rst(rst0), .start(start0), .busy(busy0), .done(done0),
        .dut_a(a0), .dut_b(b0), .dut_p(p0), .err_count(err0),
        .first_err_valid(fev0), .first_err_a(fea0), .first_err_b(feb0),
        .first_err_p(fep0), .pass(pass0)
    );

    mult_eval_sweep #(.WIDTH(2), .PIPE_LAT(2)) u2 (
        .clk(clk), .rst(rst2), .start(start2), .busy(busy2), .done(done2),
        .dut_a(a2), .dut_b(b2), .dut_p(p2), .err_count(err2),
        .first_err_valid(fev2), .first_err_a(fea2), .first_err_b(feb2),
        .first_err_p(fep2), .pass(pass2)
    );

    // Start sampled at edge 0; observes cycles 1..40 at negedges.
    task automatic do_sweep(input bit sel, output int done_at, output int busy_n, output int done_n);
        @(negedge clk);
        if (sel) start2 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start2 = 1'b0;
        done_at = -1;
        busy_n  = 0;
        done_n  = 0;
        for (int c = 1; c <= 40; c++) begin
            if (sel ? busy2 : busy0) busy_n++;
            if (sel ? done2 : done0) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
            if (c < 40) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst0 = 1'b1;
        rst2 = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy0, done0, a0, b0, err0, fev0, fea0, feb0, fep0, pass0} !== 20'd0) begin
            errors++;
            $display("FAIL reset_u0: got %h required 0",
                     {busy0, done0, a0, b0, err0, fev0, fea0, feb0, fep0, pass0});
        end
        checks++;
        if ({busy2, done2, a2, b2, err2, fev2, pass2} !== 14'd0) begin
            errors++;
            $display("FAIL reset_u2: got %h required 0", {busy2, done2, a2, b2, err2, fev2, pass2});
        end
        rst0 = 1'b0;
        rst2 = 1'b0;
    endtask

    task automatic test_golden;
        int d, bn, dn;
        mode = 0;
        do_sweep(1'b0, d, bn, dn);
        checks++;
        if (d !== 17) begin errors++; $display("FAIL golden_done_cycle: got %0d required 17", d); end
        checks++;
        if (bn !== 16) begin errors++; $display("FAIL golden_busy_cycles: got %0d required 16", bn); end
        checks++;
        if (dn !== 1) begin errors++; $display("FAIL golden_done_pulses: got %0d required 1", dn); end
        checks++;
        if (err0 !== 5'd0) begin errors++; $display("FAIL golden_err: got %0d required 0", err0); end
        checks++;
        if (pass0 !== 1'b1) begin errors++; $display("FAIL golden_pass: got %b required 1", pass0); end
        checks++;
        if (fev0 !== 1'b0) begin errors++; $display("FAIL golden_fev: got %b required 0", fev0); end
    endtask

    task automatic test_zero_product;
        int d, bn, dn;
        mode = 1;
        do_sweep(1'b0, d, bn, dn);
        checks++;
        if (err0 !== 5'd9) begin errors++; $display("FAIL zero_err: got %0d required 9", err0); end
        checks++;
        if ({fev0, fea0, feb0, fep0} !== {1'b1, 2'd1, 2'd1, 4'd0}) begin
            errors++;
            $display("FAIL zero_first: got v=%b a=%0d b=%0d p=%0d required v=1 a=1 b=1 p=0",
                     fev0, fea0, feb0, fep0);
        end
        checks++;
        if (pass0 !== 1'b0) begin errors++; $display("FAIL zero_pass: got %b required 0", pass0); end
    endtask

    task automatic test_stuck_bit0;
        int d, bn, dn;
        mode = 2;
        do_sweep(1'b0, d, bn, dn);
        checks++;
        if (err0 !== 5'd4) begin errors++; $display("FAIL stuck_err: got %0d required 4", err0); end
        checks++;
        if ({fev0, fea0, feb0, fep0} !== {1'b1, 2'd1, 2'd1, 4'd0}) begin
            errors++;
            $display("FAIL stuck_first: got v=%b a=%0d b=%0d p=%0d required v=1 a=1 b=1 p=0",
                     fev0, fea0, feb0, fep0);
        end
        checks++;
        if (pass0 !== 1'b0) begin errors++; $display("FAIL stuck_pass: got %b required 0", pass0); end
    endtask

    task automatic test_pipelined;
        int d, bn, dn;
        do_sweep(1'b1, d, bn, dn);
        checks++;
        if (d !== 19) begin errors++; $display("FAIL pipe_done_cycle: got %0d required 19", d); end
        checks++;
        if (bn !== 18) begin errors++; $display("FAIL pipe_busy_cycles: got %0d required 18", bn); end
        checks++;
        if (err2 !== 5'd0 || pass2 !== 1'b1 || fev2 !== 1'b0) begin
            errors++;
            $display("FAIL pipe_result: got err=%0d pass=%b fev=%b required 0 1 0", err2, pass2, fev2);
        end
        mode = 3;
        do_sweep(1'b0, d, bn, dn);
        checks++;
        if (err0 === 5'd0 || pass0 !== 1'b0) begin
            errors++;
            $display("FAIL pipe_unmatched_latency: got err=%0d pass=%b required err>0 pass=0", err0, pass0);
        end
    endtask

    task automatic test_back_to_back;
        int done_n, first_d, second_d;
        mode    = 1;
        done_n  = 0;
        first_d = -1;
        second_d = -1;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 45; c++) begin
            if (done0) begin
                done_n++;
                if (first_d < 0) first_d = c; else second_d = c;
            end
            if (c == 18) begin
                checks++;
                if (err0 !== 5'd9) begin errors++; $display("FAIL b2b_held_err: got %0d required 9", err0); end
            end
            if (c == 19) begin
                checks++;
                if (err0 !== 5'd0 || fev0 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_cleared: got err=%0d fev=%b required 0 0", err0, fev0);
                end
            end
            start0 = (c == 5 || c == 17 || c == 18);
            @(negedge clk);
        end
        start0 = 1'b0;
        checks++;
        if (first_d !== 17 || second_d !== 35 || done_n !== 2) begin
            errors++;
            $display("FAIL b2b_done: got first=%0d second=%0d count=%0d required 17 35 2",
                     first_d, second_d, done_n);
        end
        checks++;
        if (err0 !== 5'd9) begin errors++; $display("FAIL b2b_recomputed_err: got %0d required 9", err0); end
    endtask

    task automatic test_reset_mid_sweep;
        int d, bn, dn;
        mode = 1;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int c = 1; c < 8; c++) @(negedge clk);
        checks++;
        if (err0 !== 5'd2 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_progress: got err=%0d busy=%b required 2 1", err0, busy0);
        end
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        checks++;
        if ({busy0, done0, a0, b0, err0, fev0, fea0, feb0, fep0, pass0} !== 20'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h required 0",
                     {busy0, done0, a0, b0, err0, fev0, fea0, feb0, fep0, pass0});
        end
        do_sweep(1'b0, d, bn, dn);
        checks++;
        if (d !== 17 || err0 !== 5'd9 || fea0 !== 2'd1 || feb0 !== 2'd1) begin
            errors++;
            $display("FAIL mid_resweep: got done=%0d err=%0d a=%0d b=%0d required 17 9 1 1",
                     d, err0, fea0, feb0);
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_zero_product();
        test_stuck_bit0();
        test_pipelined();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
